// File: rtl/gemm_pad_pkg.sv
// Shared constants and types for the GEMM pad-side input deserializer.
// Every default here describes the standard 16-bit pad / 128-bit core configuration.
package gemm_pad_pkg;

  localparam int DEF_PAD_W  = 16;
  localparam int DEF_WORD_W = 128;
  localparam int DEF_DEPTH  = 4;

  localparam int BEATS  = DEF_WORD_W / DEF_PAD_W;
  localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W  = $clog2(DEF_DEPTH + 1);

  typedef logic [DEF_PAD_W-1:0]  pad_beat_t;
  typedef logic [DEF_WORD_W-1:0] gemm_word_t;

  // Pointer width that stays legal for a depth of one.
  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gemm_sync_fifo.sv
// Show-ahead synchronous FIFO: the head entry is visible whenever the FIFO is not empty.
// When full, a push is accepted only if a pop happens on the same edge.
module gemm_sync_fifo
  import gemm_pad_pkg::*;
#(
  parameter int WIDTH = DEF_WORD_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int PTR_W = safe_clog2(DEPTH);
  localparam int FCNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [FCNT_W-1:0] r_count;
  logic              w_do_push;
  logic              w_do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full    = (r_count == FCNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_count   = r_count;
  assign o_rdata   = o_empty ? '0 : r_mem[r_rptr];

  // When full, the write slot equals the head slot being popped on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= next_ptr(r_wptr);
      end
      if (w_do_pop) begin
        r_rptr <= next_ptr(r_rptr);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/gemm_input_deser.sv
// Pad-to-core deserializer: packs PAD_W beats LSB-first into WORD_W words, buffers
// them in a FIFO and returns one credit per word consumed by the GEMM core.
module gemm_input_deser
  import gemm_pad_pkg::*;
#(
  parameter int PAD_W  = DEF_PAD_W,
  parameter int WORD_W = DEF_WORD_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PAD_W-1:0]           pad_data,
  input  logic                       pad_valid,
  output logic                       pad_credit,
  output logic [WORD_W-1:0]          input_rsc_z,
  output logic                       input_rsc_vz,
  input  logic                       input_rsc_lz,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       ovf_err
);

  localparam int NBEATS  = WORD_W / PAD_W;
  localparam int NBCNT_W = safe_clog2(NBEATS);

  logic [NBCNT_W-1:0] r_bcnt;
  logic [WORD_W-1:0]  r_partial;
  logic               r_credit;
  logic               r_ovf;
  logic [WORD_W-1:0]  w_word;
  logic               w_last;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;

  assign w_last = pad_valid && (r_bcnt == NBCNT_W'(NBEATS - 1));
  assign w_pop  = input_rsc_lz && !w_empty;

  // The completed word carries the final beat straight from the pads.
  always_comb begin
    w_word = r_partial;
    w_word[(NBEATS-1)*PAD_W +: PAD_W] = pad_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bcnt    <= '0;
      r_partial <= '0;
    end else if (pad_valid) begin
      if (w_last) begin
        r_bcnt    <= '0;
        r_partial <= '0;
      end else begin
        r_partial[int'(r_bcnt)*PAD_W +: PAD_W] <= pad_data;
        r_bcnt <= r_bcnt + 1'b1;
      end
    end
  end

  // A word arriving at a full FIFO with no pop is dropped and flagged permanently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf    <= 1'b0;
      r_credit <= 1'b0;
    end else begin
      r_credit <= w_pop;
      if (w_last && w_full && !w_pop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  gemm_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (w_last),
    .i_wdata (w_word),
    .i_pop   (w_pop),
    .o_rdata (input_rsc_z),
    .o_count (fifo_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign input_rsc_vz = !w_empty;
  assign pad_credit   = r_credit;
  assign ovf_err      = r_ovf;

endmodule

// File: tb/tb_gemm_input_deser.sv
// Self-checking bench for gemm_input_deser: directed scenarios plus a randomized run,
// all compared against a queue-based word-level model of the deserializer.
module tb_gemm_input_deser;

  localparam int PW = 16;
  localparam int WW = 128;
  localparam int D  = 4;
  localparam int NB = WW / PW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PW-1:0] pad_data = '0;
  logic          pad_valid = 1'b0;
  logic          input_rsc_lz = 1'b0;
  logic          pad_credit;
  logic [WW-1:0] input_rsc_z;
  logic          input_rsc_vz;
  logic [2:0]    fifo_count;
  logic          ovf_err;

  int checks = 0;
  int failures = 0;

  logic [WW-1:0] mq[$];
  logic [PW-1:0] mbeats[$];
  bit            movf;
  bit            mcredit;

  gemm_input_deser #(.PAD_W(PW), .WORD_W(WW), .DEPTH(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .pad_data     (pad_data),
    .pad_valid    (pad_valid),
    .pad_credit   (pad_credit),
    .input_rsc_z  (input_rsc_z),
    .input_rsc_vz (input_rsc_vz),
    .input_rsc_lz (input_rsc_lz),
    .fifo_count   (fifo_count),
    .ovf_err      (ovf_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mq.delete();
    mbeats.delete();
    movf = 0;
    mcredit = 0;
  endtask

  // Drive one cycle of inputs, advance the word-level model on the edge, settle 1ns.
  task automatic tick(input bit v, input logic [PW-1:0] d, input bit lz);
    bit pop;
    bit push;
    logic [WW-1:0] w;
    @(negedge clk);
    pad_valid = v;
    pad_data = d;
    input_rsc_lz = lz;
    @(posedge clk);
    pop = (mq.size() > 0) && lz;
    push = 0;
    w = '0;
    if (v) begin
      mbeats.push_back(d);
      if (mbeats.size() == NB) begin
        for (int i = 0; i < NB; i++) w[i*PW +: PW] = mbeats[i];
        mbeats.delete();
        push = 1;
      end
    end
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (mq.size() < D) mq.push_back(w);
      else movf = 1;
    end
    mcredit = pop;
    #1;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b0;
    pad_valid = 1'b0;
    input_rsc_lz = 1'b0;
    model_reset();
    #3;
    rst = 1'b1;
  endtask

  task automatic send_word(input logic [PW-1:0] b[NB], input bit lz_last, output logic [WW-1:0] w);
    w = '0;
    for (int i = 0; i < NB; i++) begin
      w[i*PW +: PW] = b[i];
      tick(1'b1, b[i], (i == NB-1) ? lz_last : 1'b0);
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      pad_valid = 1'($urandom_range(0, 1));
      input_rsc_lz = 1'($urandom_range(0, 1));
      pad_data = 16'($urandom);
      @(posedge clk);
      #1;
      checks++;
      if ({pad_credit, input_rsc_vz, ovf_err} !== 3'b000 || input_rsc_z !== '0 || fifo_count !== 3'd0) begin
        failures++;
        $display("[TB] FAIL reset_hold: credit=%b vz=%b ovf=%b count=%0d z=%h required all zero",
                 pad_credit, input_rsc_vz, ovf_err, fifo_count, input_rsc_z);
      end
    end
    @(negedge clk);
    pad_valid = 1'b0;
    input_rsc_lz = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (fifo_count !== 3'd0) begin
      failures++;
      $display("[TB] FAIL reset_release_count: got %0d required 0", fifo_count);
    end
  endtask

  task automatic test_single_word();
    logic [WW-1:0] exp_w;
    exp_w = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
    reset_dut();
    for (int i = 1; i <= NB; i++) begin
      tick(1'b1, 16'(i), 1'b1);
      if (i == NB-1) begin
        checks++;
        if (input_rsc_vz !== 1'b0) begin
          failures++;
          $display("[TB] FAIL single_early_vz: got %b required 0", input_rsc_vz);
        end
      end
    end
    checks++;
    if (input_rsc_vz !== 1'b1 || input_rsc_z !== exp_w) begin
      failures++;
      $display("[TB] FAIL single_word: vz=%b z=%h required vz=1 z=%h", input_rsc_vz, input_rsc_z, exp_w);
    end
    checks++;
    if (pad_credit !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_early_credit: got %b required 0", pad_credit);
    end
    tick(1'b0, '0, 1'b1);
    checks++;
    if (pad_credit !== 1'b1 || input_rsc_vz !== 1'b0 || fifo_count !== 3'd0) begin
      failures++;
      $display("[TB] FAIL single_pop: credit=%b vz=%b count=%0d required 1 0 0",
               pad_credit, input_rsc_vz, fifo_count);
    end
    tick(1'b0, '0, 1'b0);
    checks++;
    if (pad_credit !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_credit_once: got %b required 0", pad_credit);
    end
  endtask

  task automatic test_fill_overflow();
    logic [PW-1:0] b[NB];
    logic [WW-1:0] words[5];
    int got;
    int creds;
    reset_dut();
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < NB; i++) b[i] = 16'($urandom);
      send_word(b, 1'b0, words[k]);
      if (k >= 3) begin
        checks++;
        if (fifo_count !== 3'd4 || ovf_err !== (k == 4)) begin
          failures++;
          $display("[TB] FAIL fill_word%0d: count=%0d ovf=%b required 4 %b", k+1, fifo_count, ovf_err, k == 4);
        end
      end
    end
    got = 0;
    creds = 0;
    for (int c = 0; c < 12; c++) begin
      if (input_rsc_vz === 1'b1) begin
        checks++;
        if (got >= 4 || input_rsc_z !== words[got]) begin
          failures++;
          $display("[TB] FAIL drain_word%0d: got %h required %h", got, input_rsc_z,
                   (got < 4) ? words[got] : '0);
        end
        got++;
      end
      tick(1'b0, '0, 1'b1);
      if (pad_credit === 1'b1) creds++;
    end
    checks++;
    if (got != 4 || creds != 4 || ovf_err !== 1'b1) begin
      failures++;
      $display("[TB] FAIL drain_totals: words=%0d credits=%0d ovf=%b required 4 4 1", got, creds, ovf_err);
    end
  endtask

  task automatic test_full_push_pop();
    logic [PW-1:0] b[NB];
    logic [WW-1:0] words[4];
    logic [WW-1:0] exp_w[4];
    logic [WW-1:0] neww;
    int got;
    reset_dut();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < NB; i++) b[i] = 16'($urandom);
      send_word(b, 1'b0, words[k]);
    end
    for (int i = 0; i < NB; i++) b[i] = 16'($urandom);
    send_word(b, 1'b1, neww);
    checks++;
    if (fifo_count !== 3'd4 || ovf_err !== 1'b0 || pad_credit !== 1'b1) begin
      failures++;
      $display("[TB] FAIL full_push_pop: count=%0d ovf=%b credit=%b required 4 0 1",
               fifo_count, ovf_err, pad_credit);
    end
    exp_w[0] = words[1];
    exp_w[1] = words[2];
    exp_w[2] = words[3];
    exp_w[3] = neww;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      if (input_rsc_vz === 1'b1) begin
        checks++;
        if (got >= 4 || input_rsc_z !== exp_w[got]) begin
          failures++;
          $display("[TB] FAIL fullpp_order%0d: got %h required %h", got, input_rsc_z,
                   (got < 4) ? exp_w[got] : '0);
        end
        got++;
      end
      tick(1'b0, '0, 1'b1);
    end
    checks++;
    if (got != 4) begin
      failures++;
      $display("[TB] FAIL fullpp_total: words=%0d required 4", got);
    end
  endtask

  task automatic test_gapped();
    logic [WW-1:0] exp_w;
    logic [PW-1:0] d;
    reset_dut();
    exp_w = '0;
    for (int i = 0; i < NB; i++) begin
      d = 16'($urandom);
      exp_w[i*PW +: PW] = d;
      tick(1'b1, d, 1'b0);
      if (i == NB-1) break;
      tick(1'b0, 16'($urandom), 1'b0);
      tick(1'b0, 16'($urandom), 1'b0);
    end
    checks++;
    if (input_rsc_vz !== 1'b1 || input_rsc_z !== exp_w || fifo_count !== 3'd1) begin
      failures++;
      $display("[TB] FAIL gapped_word: vz=%b count=%0d z=%h required 1 1 %h",
               input_rsc_vz, fifo_count, input_rsc_z, exp_w);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [WW-1:0] exp_w;
    exp_w = 128'h00A7_00A6_00A5_00A4_00A3_00A2_00A1_00A0;
    reset_dut();
    for (int i = 0; i < 3; i++) tick(1'b1, 16'($urandom), 1'b0);
    reset_dut();
    for (int i = 0; i < NB; i++) tick(1'b1, 16'h00A0 + 16'(i), 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, '0, 1'b0);
    checks++;
    if (input_rsc_vz !== 1'b1 || input_rsc_z !== exp_w || fifo_count !== 3'd1) begin
      failures++;
      $display("[TB] FAIL reset_mid_word: vz=%b count=%0d z=%h required 1 1 %h",
               input_rsc_vz, fifo_count, input_rsc_z, exp_w);
    end
    tick(1'b0, '0, 1'b1);
    checks++;
    if (input_rsc_vz !== 1'b0 || fifo_count !== 3'd0) begin
      failures++;
      $display("[TB] FAIL reset_mid_single: vz=%b count=%0d required 0 0", input_rsc_vz, fifo_count);
    end
  endtask

  task automatic test_random();
    bit v;
    bit lz;
    reset_dut();
    for (int c = 0; c < 3000; c++) begin
      v = ($urandom_range(0, 3) != 0);
      lz = (c < 1500) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) == 0);
      tick(v, 16'($urandom), lz);
      checks++;
      if (input_rsc_vz !== (mq.size() > 0) || fifo_count !== 3'(mq.size()) ||
          ovf_err !== movf || pad_credit !== mcredit) begin
        failures++;
        $display("[TB] FAIL random_ctrl@%0d: vz=%b count=%0d ovf=%b credit=%b required %b %0d %b %b",
                 c, input_rsc_vz, fifo_count, ovf_err, pad_credit,
                 mq.size() > 0, mq.size(), movf, mcredit);
      end
      if (mq.size() > 0) begin
        checks++;
        if (input_rsc_z !== mq[0]) begin
          failures++;
          $display("[TB] FAIL random_head@%0d: got %h required %h", c, input_rsc_z, mq[0]);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_word();
    test_fill_overflow();
    test_full_push_pop();
    test_gapped();
    test_reset_mid_word();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gemm_input_deser.md
# gemm_input_deser

Input-side pad deserializer for the GEMM accelerator. It sits directly upstream of the GEMM core's 128-bit input channel. It accepts 16-bit beats from chip pads under credit-based flow control and assembles them into 128-bit words. Words are buffered in a small FIFO and presented on the core's `input_rsc_z`/`vz`/`lz` handshake.

## Interface
Parameters:
- `PAD_W`, 16, pad beat width in bits.
- `WORD_W`, 128, assembled word width; must be an integer multiple of `PAD_W`.
- `DEPTH`, 4, FIFO depth in words; equals the sender's initial credit count.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-low reset.
- `pad_data`  in  `PAD_W`  beat payload.
- `pad_valid`  in  1  beat present this cycle.
- `pad_credit`  out  1  one-cycle pulse that returns one word credit to the sender.
- `input_rsc_z`  out  `WORD_W`  FIFO head word.
- `input_rsc_vz`  out  1  head word valid (FIFO not empty).
- `input_rsc_lz`  in  1  core reads this cycle.
- `fifo_count`  out  `$clog2(DEPTH+1)`  words currently stored.
- `ovf_err`  out  1  sticky overflow flag.

## Operation
- `BEATS = WORD_W/PAD_W` (8 at default parameters).
- Beat counter `bcnt` runs 0..BEATS-1.
  - A beat is sampled on every rising edge where `pad_valid`=1.
  - Beat i lands in bits `[i*PAD_W +: PAD_W]`, so the first beat is the LSBs.
  - Gaps (`pad_valid`=0) hold `bcnt` and the partial word.
- On the edge that samples beat BEATS-1, the completed word (partial register plus current beat) is pushed into the FIFO, and `bcnt` wraps to 0 in the same edge.
- Pop: on any edge where `input_rsc_vz`=1 and `input_rsc_lz`=1, the head word advances.
  - `input_rsc_lz` while empty has no effect.
- Push and pop on the same edge are both honoured.
  - If the FIFO is full, the simultaneous push succeeds and `fifo_count` is unchanged.
  - If the FIFO is empty, the pushed word appears at the head on the next cycle. There is no bypass.
- Overflow: a push while full with no simultaneous pop drops the word.
  - `ovf_err` is set and stays set until reset.
  - FIFO contents are not disturbed.
- Credits are counted in words. Each pop produces exactly one `pad_credit` pulse. Dropped words return no credit.
- A compliant sender starts a word only while holding a credit. `ovf_err` therefore only indicates protocol violation.

## Timing
- Reset values: `pad_credit`=0, `input_rsc_vz`=0, `input_rsc_z`=0, `fifo_count`=0, `ovf_err`=0.
  - `bcnt` and the partial word are also cleared.
  - Reset clears FIFO storage and pointers.
- Reset asserted mid-word discards the partial word. The first beat after deassertion is beat 0.
- Latency: last beat sampled at edge N gives `input_rsc_vz`=1 and valid `input_rsc_z` in the cycle after N. This holds when the FIFO was empty.
- `input_rsc_z` is the registered head entry. It is stable while `input_rsc_vz`=1 and no pop occurs.
- `pad_credit` is registered. It is high for exactly the cycle following each pop edge, so back-to-back pops give back-to-back pulses.
- Throughput: one beat per cycle in, one word per cycle out. Steady state runs at one word per BEATS cycles with no bubbles.
- `fifo_count` updates on the push/pop edge: +1 on push only, −1 on pop only, unchanged on both or neither.
- `ovf_err` rises in the cycle after the offending edge.

## Structure
- Shared package `gemm_pad_pkg` holds:
  - `PAD_W`, `WORD_W` defaults and `BEATS`.
  - Derived `BCNT_W` and `CNT_W` widths.
  - Typedefs `pad_beat_t` and `gemm_word_t`.
- Sub-module `gemm_sync_fifo`: a parameterised show-ahead synchronous FIFO with width, depth, push/pop, count, full/empty and async active-low reset.
- The top contains the beat assembler, overflow logic and credit register.

## Test plan
- Reset: hold `rst`=0 with random `pad_valid`/`input_rsc_lz` -> all outputs 0 throughout; `fifo_count`=0 after release.
- Single word: beats 0x0001..0x0008 back-to-back with `input_rsc_lz`=1 -> `input_rsc_z`=0x0008_0007_0006_0005_0004_0003_0002_0001. `input_rsc_vz` is high exactly one cycle after the 8th beat, the pop happens that cycle, and `pad_credit` pulses once on the next cycle.
- Fill and overflow: `input_rsc_lz`=0, send 5 words -> `fifo_count`=4 and `ovf_err`=1 after the 5th word. Then raise `lz` -> words 1-4 drain in order, 4 credit pulses, word 5 never appears.
- Full with simultaneous push/pop: `fifo_count`=4, 8th beat of a new word on the same edge as a pop -> `fifo_count` stays 4, `ovf_err`=0, new word is last in order.
- Gapped input: 8 beats with `pad_valid` pattern 1,0,0,1,... -> same assembled word as back-to-back; `bcnt` is unaffected by idle cycles.
- Reset mid-word: 3 beats, pulse `rst`=0, then 8 beats 0xA0..0xA7 -> exactly one word 0x00A7_00A6_..._00A0; no trace of the earlier beats.
